// File: rtl/fc_g3_seq.sv
// fc_g3_seq: sequencer for fully-connected layer G3.
// Walks every (neuron, input-pair) of the layer, issuing two weight and two activation
// reads per cycle. The returning data goes through two signed MACs per cycle, and the
// block emits one saturated Q8.8 result for each output neuron.
module fc_g3_seq #(
   parameter int N_IN  = 32,
   parameter int N_OUT = 16,
   parameter int WAW   = 9,
   parameter int AAW   = 5,
   parameter int OIW   = 4,
   parameter int FRAC  = 8
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_start,
   output logic             o_busy,
   output logic             o_done,
   output logic [WAW-1:0]   o_w_addr_a,
   output logic [WAW-1:0]   o_w_addr_b,
   input  logic [15:0]      i_w_q_a,
   input  logic [15:0]      i_w_q_b,
   output logic [AAW-1:0]   o_act_addr_a,
   output logic [AAW-1:0]   o_act_addr_b,
   input  logic [15:0]      i_act_q_a,
   input  logic [15:0]      i_act_q_b,
   output logic             o_out_valid,
   output logic [OIW-1:0]   o_out_idx,
   output logic [15:0]      o_out_data
);

   // k counts input pairs, so it needs one bit fewer than an activation address.
   localparam int KW   = (AAW > 1) ? AAW - 1 : 1;
   localparam int ACCW = 32 + AAW + 1;
   localparam logic [KW-1:0]  K_LAST = KW'(N_IN / 2 - 1);
   localparam logic [OIW-1:0] N_LAST = OIW'(N_OUT - 1);
   localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(32767);
   localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-32768);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                  r_state, w_state_nxt;
   logic [OIW-1:0]          r_n;
   logic [KW-1:0]           r_k;
   logic                    w_k_last, w_n_last;

   // Issue tag: this is the stage-1 side of the MAC pipeline.
   logic                    r_t_vld, r_t_first, r_t_last;
   logic [OIW-1:0]          r_t_idx;

   logic signed [31:0]      w_p_a, w_p_b;
   logic signed [ACCW-1:0]  w_p, w_acc_in, w_sum, w_shr;
   logic signed [ACCW-1:0]  r_acc;
   logic [15:0]             w_sat;

   logic                    r_out_valid;
   logic [OIW-1:0]          r_out_idx;
   logic [15:0]             r_out_data;

   assign w_k_last = (r_k == K_LAST);
   assign w_n_last = (r_n == N_LAST);

   // State register, updated on the clock edge.
   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next-state logic. A start that arrives outside IDLE is dropped.
   // DRAIN waits for the strobe of the last neuron.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_state_nxt = S_RUN;
         S_RUN:   if (w_k_last && w_n_last) w_state_nxt = S_DRAIN;
         S_DRAIN: if (r_out_valid) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Neuron / pair counters. They only advance in RUN and sit at zero otherwise.
   always_ff @(posedge i_clock) begin
      if (i_reset || r_state != S_RUN) begin
         r_n <= '0;
         r_k <= '0;
      end else if (w_k_last) begin
         r_k <= '0;
         r_n <= w_n_last ? '0 : r_n + 1'b1;
      end else begin
         r_k <= r_k + 1'b1;
      end
   end

   // Read addresses come straight from the counters during RUN and are 0 elsewhere.
   always_comb begin
      o_w_addr_a   = '0;
      o_w_addr_b   = '0;
      o_act_addr_a = '0;
      o_act_addr_b = '0;
      if (r_state == S_RUN) begin
         o_act_addr_a = {r_k, 1'b0};
         o_act_addr_b = {r_k, 1'b1};
         o_w_addr_a   = WAW'(r_n) * WAW'(N_IN) + WAW'(o_act_addr_a);
         o_w_addr_b   = o_w_addr_a + 1'b1;
      end
   end

   assign o_busy = (r_state != S_IDLE);
   assign o_done = (r_state == S_DONE);

   // Stage-1 tag. It tracks the memories' one-cycle read latency.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_t_vld   <= 1'b0;
         r_t_first <= 1'b0;
         r_t_last  <= 1'b0;
         r_t_idx   <= '0;
      end else begin
         r_t_vld   <= (r_state == S_RUN);
         r_t_first <= (r_k == '0);
         r_t_last  <= w_k_last;
         r_t_idx   <= r_n;
      end
   end

   // Stage-2 datapath: dual signed product, then accumulate. A first tag restarts the sum.
   assign w_p_a    = $signed(i_w_q_a) * $signed(i_act_q_a);
   assign w_p_b    = $signed(i_w_q_b) * $signed(i_act_q_b);
   assign w_p      = ACCW'(w_p_a) + ACCW'(w_p_b);
   assign w_acc_in = r_t_first ? '0 : r_acc;
   assign w_sum    = w_acc_in + w_p;
   assign w_shr    = w_sum >>> FRAC;

   // Clamp the floor-shifted sum into the Q8.8 range.
   always_comb begin
      w_sat = w_shr[15:0];
      if (w_shr > SAT_MAX)      w_sat = 16'h7FFF;
      else if (w_shr < SAT_MIN) w_sat = 16'h8000;
   end

   // Accumulator and result register. out_valid is a single-cycle strobe; idx and data hold.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_acc       <= '0;
         r_out_valid <= 1'b0;
         r_out_idx   <= '0;
         r_out_data  <= '0;
      end else begin
         r_out_valid <= 1'b0;
         if (r_t_vld) begin
            r_acc <= w_sum;
            if (r_t_last) begin
               r_out_valid <= 1'b1;
               r_out_idx   <= r_t_idx;
               r_out_data  <= w_sat;
            end
         end
      end
   end

   assign o_out_valid = r_out_valid;
   assign o_out_idx   = r_out_idx;
   assign o_out_data  = r_out_data;

endmodule

// File: tb/tb_fc_g3_seq.sv
// tb_fc_g3_seq: directed bench for fc_g3_seq, using registered ROM/buffer models.
module tb_fc_g3_seq;
   localparam int N_IN = 32, N_OUT = 16, WAW = 9, AAW = 5, OIW = 4, FRAC = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             busy, done, out_valid;
   logic [WAW-1:0]   w_addr_a, w_addr_b;
   logic [AAW-1:0]   act_addr_a, act_addr_b;
   logic [15:0]      w_q_a = '0, w_q_b = '0, act_q_a = '0, act_q_b = '0;
   logic [OIW-1:0]   out_idx;
   logic [15:0]      out_data;

   logic [15:0]      wrom [N_IN*N_OUT];
   logic [15:0]      arom [N_IN];
   logic [15:0]      exp_d [N_OUT];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fc_g3_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .WAW(WAW), .AAW(AAW), .OIW(OIW), .FRAC(FRAC)) dut (
      .i_clock(clk), .i_reset(rst), .i_start(start),
      .o_busy(busy), .o_done(done),
      .o_w_addr_a(w_addr_a), .o_w_addr_b(w_addr_b),
      .i_w_q_a(w_q_a), .i_w_q_b(w_q_b),
      .o_act_addr_a(act_addr_a), .o_act_addr_b(act_addr_b),
      .i_act_q_a(act_q_a), .i_act_q_b(act_q_b),
      .o_out_valid(out_valid), .o_out_idx(out_idx), .o_out_data(out_data)
   );

   // Memories with a one-cycle registered read.
   always @(posedge clk) begin
      w_q_a   <= wrom[w_addr_a];
      w_q_b   <= wrom[w_addr_b];
      act_q_a <= arom[act_addr_a];
      act_q_b <= arom[act_addr_b];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_addrs(input int c, input int wa, input int wb, input int aa, input int ab);
      check($sformatf("w_addr_a@%0d", c), 32'(w_addr_a), wa);
      check($sformatf("w_addr_b@%0d", c), 32'(w_addr_b), wb);
      check($sformatf("act_addr_a@%0d", c), 32'(act_addr_a), aa);
      check($sformatf("act_addr_b@%0d", c), 32'(act_addr_b), ab);
   endtask

   // Run one pass over cycles 0..259, where start is applied in cycle 0. Extra start
   // pulses go at p1/p2, and rst_cyc >= 0 asserts reset for that single cycle.
   // The task returns at the start of cycle 260.
   task automatic run_pass(input string name, input int p1, input int p2, input int rst_cyc);
      int  nres = 0;
      bit  ab, exp_vld;
      for (int c = 0; c < 260; c++) begin
         rst   = (c == rst_cyc);
         start = (c == 0 || c == p1 || c == p2);
         @(negedge clk);
         ab      = (rst_cyc >= 0 && c > rst_cyc);
         exp_vld = (c >= 18 && (c - 18) % 16 == 0 && !ab);
         check($sformatf("%s busy@%0d", name, c), 32'(busy), 32'(c >= 1 && c <= 259 && !ab));
         check($sformatf("%s done@%0d", name, c), 32'(done), 32'(c == 259 && !ab));
         check($sformatf("%s out_valid@%0d", name, c), 32'(out_valid), 32'(exp_vld));
         if (exp_vld) begin
            check($sformatf("%s out_idx@%0d", name, c), 32'(out_idx), (c - 18) / 16);
            check($sformatf("%s out_data@%0d", name, c), 32'(out_data), 32'(exp_d[(c - 18) / 16]));
         end
         if (out_valid) nres++;
         if (c == 0)                check_addrs(c, 0, 0, 0, 0);
         if (c == 1)                check_addrs(c, 0, 1, 0, 1);
         if (c == 17)               check_addrs(c, 32, 33, 0, 1);
         if (c == 256 && !ab)       check_addrs(c, 510, 511, 30, 31);
         if (c == 257)              check_addrs(c, 0, 0, 0, 0);
         if (rst_cyc >= 0 && c == rst_cyc + 1) check_addrs(c, 0, 0, 0, 0);
         @(posedge clk);
         #1;
      end
      rst   = 1'b0;
      start = 1'b0;
      check($sformatf("%s result_count", name), nres, (rst_cyc >= 0) ? 6 : 16);
   endtask

   task automatic load_all(input logic [15:0] w, input logic [15:0] a, input logic [15:0] e);
      for (int i = 0; i < N_IN*N_OUT; i++) wrom[i] = w;
      for (int i = 0; i < N_IN; i++) arom[i] = a;
      for (int n = 0; n < N_OUT; n++) exp_d[n] = e;
   endtask

   initial begin
      load_all(16'h0000, 16'h0000, 16'h0000);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst busy", 32'(busy), 0);
      check("rst done", 32'(done), 0);
      check("rst out_valid", 32'(out_valid), 0);
      check("rst out_idx", 32'(out_idx), 0);
      check("rst out_data", 32'(out_data), 0);
      check_addrs(-1, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Pass 1 uses all 1.0, so every neuron gives 32 * 1.0 = 0x2000. Starts at 50/259 must be ignored.
      load_all(16'h0100, 16'h0100, 16'h2000);
      run_pass("ones", 50, 259, -1);

      // Pass 2 begins right away at cycle 260. Diagonal weights select act[n] = n.
      load_all(16'h0000, 16'h0000, 16'h0000);
      for (int i = 0; i < N_IN; i++) arom[i] = 16'(i * 256);
      for (int n = 0; n < N_OUT; n++) begin
         wrom[n*N_IN + n] = 16'h0100;
         exp_d[n]         = 16'(n * 256);
      end
      run_pass("diag", -1, -1, -1);

      // Saturation: even neurons 0x7FFF*0x7FFF clamp high, odd neurons 0x8000*0x7FFF clamp low.
      load_all(16'h7FFF, 16'h7FFF, 16'h7FFF);
      for (int n = 1; n < N_OUT; n += 2) begin
         for (int i = 0; i < N_IN; i++) wrom[n*N_IN + i] = 16'h8000;
         exp_d[n] = 16'h8000;
      end
      run_pass("sat", -1, -1, -1);

      // Truncation: a single tiny product per neuron; +1/256 floors to 0 and -1/256 floors to -1.
      load_all(16'h0000, 16'h0001, 16'h0000);
      for (int n = 0; n < N_OUT; n++) begin
         wrom[n*N_IN + n] = (n % 2 == 0) ? 16'h0001 : 16'hFFFF;
         exp_d[n]         = (n % 2 == 0) ? 16'h0000 : 16'hFFFF;
      end
      run_pass("trunc", -1, -1, -1);

      // Reset mid-pass at cycle 100: neurons 0..5 come out, then nothing more.
      load_all(16'h0100, 16'h0100, 16'h2000);
      run_pass("abort", -1, -1, 100);

      // After the abort, a complete pass must still be correct.
      run_pass("after_abort", -1, -1, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fc_g3_seq.md
Name: fc_g3_seq

Overview:
- Sequencer for fully-connected layer G3: drives both ports of the 512x16 dual-port weight ROM and a dual-port activation buffer.
- Performs two signed fixed-point MACs per cycle and emits one saturated Q8.8 result per output neuron.
- Sits between the layer start/done control chain and the downstream result buffer.
- Neuron-to-neuron issue is back-to-back, with no bubbles.

Parameters:
- N_IN, 32, inputs per neuron; must be even.
- N_OUT, 16, output neurons; N_IN*N_OUT <= 2^WAW.
- WAW, 9, weight address width.
- AAW, 5, activation address width, = log2(N_IN).
- OIW, 4, output index width, = log2(N_OUT).
- FRAC, 8, fractional bits of Q-format data.

Ports:
- clock, in, 1, sole clock; all logic on posedge.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, single-cycle request; sampled only in IDLE.
- busy, out, 1, high while a layer pass is in progress.
- done, out, 1, one-cycle pulse at end of pass.
- w_addr_a, out, WAW, weight ROM port A address.
- w_addr_b, out, WAW, weight ROM port B address.
- w_q_a, in, 16, ROM port A data, signed Q8.8; 1-cycle registered latency.
- w_q_b, in, 16, ROM port B data, same format and latency.
- act_addr_a, out, AAW, activation buffer port A address.
- act_addr_b, out, AAW, activation buffer port B address.
- act_q_a, in, 16, activation port A data, signed Q8.8; 1-cycle latency.
- act_q_b, in, 16, activation port B data, same format and latency.
- out_valid, out, 1, result strobe.
- out_idx, out, OIW, neuron index of the result.
- out_data, out, 16, signed Q8.8 result.

Behaviour:
- Reset:
  - State goes to IDLE.
  - busy, done, out_valid, out_idx, out_data, all addresses and counters = 0.
  - Accumulator and pipeline-valid bits cleared.
  - Reset mid-pass aborts immediately; data returning afterwards is ignored.
- States:
  - IDLE: addresses held 0. start=1 -> RUN, with n=0, k=0.
  - RUN: each cycle issue w_addr_a = n*N_IN + 2k, w_addr_b = w_addr_a + 1, act_addr_a = 2k, act_addr_b = 2k + 1.
    - k increments; at k = N_IN/2 - 1, k wraps to 0 and n increments.
    - After issuing (n = N_OUT-1, k = N_IN/2 - 1) -> DRAIN; addresses return to 0.
  - DRAIN: waits for final out_valid, then -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- busy:
  - Goes high the cycle after start is accepted.
  - Stays high through the DONE cycle.
  - start while not IDLE is ignored; no queuing.
- Pipeline, stage 1 (issue cycle): a registered tag travels with each issue: valid, first (k=0), last (k = N_IN/2 - 1), neuron index.
- Pipeline, stage 2 (data cycle, one after issue):
  - p = w_q_a*act_q_a + w_q_b*act_q_b, 32-bit signed products, sign-extended.
  - Accumulator width 32 + AAW + 1 bits.
  - acc <= first ? p : acc + p.
- Output: on a last tag, register result = sat16((acc_in + p) >>> FRAC).
  - acc_in is 0 when first is also set.
  - Shift is arithmetic and truncating (floor).
  - Saturation clamps to [-32768, 32767].
  - out_valid=1 and out_idx = tag neuron in the following cycle.
- out_valid is a one-cycle strobe with no backpressure. out_data/out_idx hold their last value otherwise.
- Latency with start accepted at cycle 0:
  - First issue at cycle 1.
  - Neuron n result at cycle 18 + 16n (N_IN=32).
  - Final result at cycle 258; done at 259; busy high for cycles 1..259.
- Next start is accepted in the cycle after done, when the block is back in IDLE.

Test Plan:
- All weights 0x0100, all acts 0x0100, start at cycle 0:
  - out_valid at cycles 18, 34, …, 258 with out_idx 0..15.
  - out_data = 0x2000 on every result.
  - done at 259; busy high 1..259.
- Address check, same run:
  - Cycle 1: w_addr_a/b = 0/1, act_addr = 0/1.
  - Cycle 17: w_addr = 32/33, act_addr = 0/1.
  - Cycle 256: w_addr = 510/511.
  - Cycle 257: all addresses 0.
- Diagonal weights (neuron n: 0x0100 at input n, else 0), act[i] = i*0x0100 -> out_data for neuron n = n*0x0100.
- Saturation and truncation:
  - Weights 0x7FFF, acts 0x7FFF -> 0x7FFF.
  - Weights 0x8000, acts 0x7FFF -> 0x8000.
  - Single weight 0x0001 with act 0x0001 -> 0x0000.
  - Single weight 0xFFFF with act 0x0001 -> 0xFFFF.
- start pulsed at cycles 50 and 259 during a pass:
  - Both ignored; no extra results.
  - start at cycle 260 begins a new pass, first issue at 261.
- reset asserted at cycle 100:
  - Cycle 101: busy, out_valid, done = 0; addresses 0; no further out_valid.
  - A subsequent start yields a full correct 16-result pass.
